// File: rtl/password_pkg.sv
// password_pkg: shared FSM state encoding and keypad key constants for
// password_ctrl and its debouncer.
package password_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRY    = 3'd1,
    CHECK    = 3'd2,
    UNLOCKED = 3'd3,
    FAIL     = 3'd4,
    SETPW    = 3'd5,
    LOCKOUT  = 3'd6
  } pw_state_e;

  localparam logic [3:0] KEY_SET   = 4'hA;
  localparam logic [3:0] KEY_LOCK  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser plus symmetric debouncer for the raw
// keypad key-active level. A level change is accepted only after the
// synchronised input has differed from the accepted level for DEBOUNCE_CYC
// consecutive cycles; press_o pulses for one cycle, the cycle after a press
// is accepted.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   key_raw_i  : raw key-active level, asynchronous to clk
//   press_o    : one-cycle press event
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_i,
  output logic press_o
);

  localparam int unsigned     CW      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d, level_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised input disagrees with the
  // accepted level; any agreement restarts the stability window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) level_d = sync2_q;
      else                  cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= key_raw_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  assign press_o = level_q & ~level_dly_q;

endmodule

// File: rtl/password_ctrl.sv
// password_ctrl: keypad password lock. Debounced key presses are collected
// into an entry buffer, compared against the stored password on ENTER, and
// grant access (unlocked) or produce a fail pulse. While unlocked the
// password can be changed (SET) or the lock re-armed (LOCK).
// Optional feature macro: PWCTRL_LOCKOUT_EN -- MAX_FAILS consecutive failures
// lock the keypad for LOCK_CYC cycles. Without it locked_out is tied to 0.
//   clk        : 100 MHz clock
//   rst_n      : asynchronous active-low reset
//   key_code   : latest decoded key (0-9 digits, A-F commands)
//   key_down   : raw key-active level, asynchronous
//   unlocked   : high while in UNLOCKED
//   fail_pulse : one-cycle pulse per rejected attempt
//   locked_out : high during lockout
//   digit_cnt  : digits entered so far
//   state_o    : current FSM state encoding
module password_ctrl #(
  parameter int unsigned PW_LEN       = 4,
  parameter logic [27:0] PW_DEFAULT   = 28'h0001234,
  parameter int unsigned DEBOUNCE_CYC = 100000,
  parameter int unsigned MAX_FAILS    = 3,
  parameter logic [31:0] LOCK_CYC     = 32'd500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_down,
  output logic       unlocked,
  output logic       fail_pulse,
  output logic       locked_out,
  output logic [2:0] digit_cnt,
  output logic [2:0] state_o
);
  import password_pkg::*;

  localparam int unsigned BW       = 4 * PW_LEN;
  localparam logic [2:0]  CNT_FULL = 3'(PW_LEN);

  pw_state_e     state_q, state_d;
  logic [BW-1:0] buf_q, buf_d, pw_q, pw_d, buf_shift;
  logic [2:0]    cnt_q, cnt_d;
  logic          press, dig_ok, match;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw_i (key_down),
    .press_o   (press)
  );

  // New digit enters at the LSBs so the first digit ends up in the MSBs,
  // matching the stored password layout.
  assign buf_shift = BW'({buf_q, key_code});
  assign dig_ok    = press && is_digit(key_code) && (cnt_q < CNT_FULL);
  assign match     = (cnt_q == CNT_FULL) && (buf_q == pw_q);

`ifdef PWCTRL_LOCKOUT_EN
  localparam int unsigned FW = $clog2(MAX_FAILS + 1);
  logic [FW-1:0] fail_q, fail_d;
  logic [31:0]   lock_q, lock_d;
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    pw_d    = pw_q;
`ifdef PWCTRL_LOCKOUT_EN
    fail_d  = fail_q;
    lock_d  = lock_q;
`endif
    case (state_q)
      IDLE: begin
        if (dig_ok) begin
          buf_d   = buf_shift;
          cnt_d   = cnt_q + 3'd1;
          state_d = ENTRY;
        end
      end
      ENTRY, SETPW: begin
        if (dig_ok) begin
          buf_d = buf_shift;
          cnt_d = cnt_q + 3'd1;
        end else if (press && key_code == KEY_CLEAR) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (press && key_code == KEY_ENTER) begin
          if (state_q == ENTRY) begin
            state_d = CHECK;
          end else if (cnt_q == CNT_FULL) begin
            // Short entries leave SETPW untouched.
            pw_d    = buf_q;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      CHECK: begin
        if (match) begin
          // Don't leave the secret sitting in the entry buffer.
          buf_d   = '0;
          cnt_d   = '0;
          state_d = UNLOCKED;
`ifdef PWCTRL_LOCKOUT_EN
          fail_d  = '0;
`endif
        end else begin
          state_d = FAIL;
        end
      end
      UNLOCKED: begin
        if (press && key_code == KEY_LOCK)     state_d = IDLE;
        else if (press && key_code == KEY_SET) state_d = SETPW;
      end
      FAIL: begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
`ifdef PWCTRL_LOCKOUT_EN
        fail_d  = fail_q + FW'(1);
        if (int'(fail_q) + 1 >= int'(MAX_FAILS)) begin
          state_d = LOCKOUT;
          lock_d  = '0;
        end
`endif
      end
`ifdef PWCTRL_LOCKOUT_EN
      LOCKOUT: begin
        // Timer counts 0..LOCK_CYC-1, one cycle per value.
        if (lock_q == LOCK_CYC - 32'd1) begin
          lock_d  = '0;
          fail_d  = '0;
          state_d = IDLE;
        end else begin
          lock_d  = lock_q + 32'd1;
        end
      end
`endif
      default: begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      pw_q    <= PW_DEFAULT[BW-1:0];
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
    end
  end

`ifdef PWCTRL_LOCKOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q <= '0;
      lock_q <= '0;
    end else begin
      fail_q <= fail_d;
      lock_q <= lock_d;
    end
  end

  assign locked_out = (state_q == LOCKOUT);
`else
  assign locked_out = 1'b0;
`endif

  assign unlocked   = (state_q == UNLOCKED);
  assign fail_pulse = (state_q == FAIL);
  assign digit_cnt  = cnt_q;
  assign state_o    = state_q;

endmodule
